// File: rtl/mod_reduce_128_if.sv
// mod_reduce_128_if
// Groups the three valid/ready channels of the modular-reduction stage.
//   input_*   : 128-bit dividend channel (upstream -> stage)
//   modulus_* : 64-bit modulus channel   (upstream -> stage)
//   output_*  : 64-bit remainder channel (stage -> downstream)
// master: the side that supplies operands and consumes the remainder.
// slave : the reduction stage itself.
interface mod_reduce_128_if;
    logic [127:0] input_tdata;
    logic         input_tvalid;
    logic         input_tready;
    logic [63:0]  modulus_tdata;
    logic         modulus_tvalid;
    logic         modulus_tready;
    logic [63:0]  output_tdata;
    logic         output_tvalid;
    logic         output_tready;

    modport master (
        output input_tdata, input_tvalid, modulus_tdata, modulus_tvalid, output_tready,
        input  input_tready, modulus_tready, output_tdata, output_tvalid
    );

    modport slave (
        input  input_tdata, input_tvalid, modulus_tdata, modulus_tvalid, output_tready,
        output input_tready, modulus_tready, output_tdata, output_tvalid
    );
endinterface

// File: rtl/mod_reduce_128.sv
// mod_reduce_128
// Computes (128-bit dividend) mod (64-bit modulus) by restoring shift-subtract,
// one dividend bit per clock. Sits behind mult_128 to form a modular multiply.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : slave side of mod_reduce_128_if (dividend, modulus, remainder channels)
// A modulus of 0 still takes the full 128 steps and returns 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | treadys high, waiting for dividend and modulus together
// CALC  | one restoring shift-subtract step per cycle, 128 cycles
// DONE  | remainder presented, waiting for downstream handshake
module mod_reduce_128 (
    input  logic             clk,
    input  logic             rst,
    mod_reduce_128_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   div_q, div_d;
    logic [63:0]    mod_q, mod_d;
    logic [63:0]    rem_q, rem_d;
    logic [6:0]     cnt_q, cnt_d;
    logic           rdy_q, rdy_d;
    logic           vld_q, vld_d;
    logic [63:0]    dout_q, dout_d;

    // The partial remainder is always < m (< 2^64) between steps, so its top
    // bit is held implicitly as 0; the shifted trial value needs the full 65 bits.
    logic [64:0]    trial;
    logic           trial_ge;
    logic [63:0]    step_rem;

    always_comb begin
        trial    = {rem_q, div_q[127]};
        trial_ge = (trial >= {1'b0, mod_q});
        // When trial >= m the true difference is < m, so the low 64 bits of the
        // 65-bit subtraction are the whole result.
        step_rem = trial_ge ? (trial[63:0] - mod_q) : trial[63:0];
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        mod_d   = mod_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                if (bus.input_tvalid && bus.modulus_tvalid) begin
                    div_d   = bus.input_tdata;
                    mod_d   = bus.modulus_tdata;
                    rem_d   = 64'd0;
                    cnt_d   = 7'd127;
                    rdy_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                div_d = {div_q[126:0], 1'b0};
                rem_d = step_rem;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd0) begin
                    vld_d   = 1'b1;
                    dout_d  = (mod_q == 64'd0) ? 64'd0 : step_rem;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.output_tready) begin
                    vld_d   = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                vld_d   = 1'b0;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 128'd0;
            mod_q   <= 64'd0;
            rem_q   <= 64'd0;
            cnt_q   <= 7'd0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            dout_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.input_tready   = rdy_q;
    assign bus.modulus_tready = rdy_q;
    assign bus.output_tvalid  = vld_q;
    assign bus.output_tdata   = dout_q;

endmodule
